// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling 8N1 UART receiver with majority vote and false-start rejection
module uart_rx_oversample #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int OVERSAMPLE      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_frame_error,
  output logic       rx_busy
);

  localparam int TICK_DIV = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SMP_W    = $clog2(OVERSAMPLE);
  localparam int M        = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [SMP_W-1:0] SMP_A    = SMP_W'(M - 1);
  localparam logic [SMP_W-1:0] SMP_B    = SMP_W'(M);
  localparam logic [SMP_W-1:0] SMP_V    = SMP_W'(M + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             sync1;
  logic             rx_s;
  logic             prev_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       state;
  logic [SMP_W-1:0] smp_cnt;
  logic [2:0]       bit_cnt;
  logic             smp_a;
  logic             smp_b;
  logic [7:0]       shreg;
  logic             vote;
  logic             wrap;

  assign tick    = (div_cnt == DIV_LAST);
  assign wrap    = (smp_cnt == SMP_LAST);
  assign vote    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign rx_busy = (state != S_IDLE);

  // Synchroniser and edge history reset to the idle (high) line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      prev_s <= 1'b1;
    end else begin
      sync1 <= serial_rx;
      rx_s  <= sync1;
      if (tick) prev_s <= rx_s;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      smp_cnt        <= '0;
      bit_cnt        <= '0;
      smp_a          <= 1'b0;
      smp_b          <= 1'b0;
      shreg          <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      rx_valid       <= 1'b0;
      rx_frame_error <= 1'b0;
      if (tick) begin
        if (smp_cnt == SMP_A) smp_a <= rx_s;
        if (smp_cnt == SMP_B) smp_b <= rx_s;
        case (state)
          S_IDLE: begin
            if (prev_s && !rx_s) begin
              state   <= S_START;
              smp_cnt <= SMP_W'(1);
            end
          end
          S_START: begin
            if (smp_cnt == SMP_V && vote) begin
              state   <= S_IDLE;
              smp_cnt <= '0;
            end else if (wrap) begin
              state   <= S_DATA;
              smp_cnt <= '0;
              bit_cnt <= '0;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (smp_cnt == SMP_V) shreg <= {vote, shreg[7:1]};
            if (wrap) begin
              smp_cnt <= '0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= S_STOP;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
          end
          S_STOP: begin
            // Leave at the vote so the tail of the stop bit absorbs baud drift.
            if (smp_cnt == SMP_V) begin
              state   <= S_IDLE;
              smp_cnt <= '0;
              if (vote) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                rx_frame_error <= 1'b1;
              end
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
